// File: rtl/spi_types.sv
// spi_types: shared state encoding and byte width for the SPI peripheral
package spi_types;
  localparam int SPI_BYTE_BITS = 8;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RELOAD} spi_peripheral_state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: N-stage input synchronizer with rise/fall pulses
module spi_edge_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [N-1:0] q;
  logic prev;
  // Unreset chain keeps tracking the pin through rst, so no phantom edge appears on release
  always_ff @(posedge clk) begin
    q <= {q[N-2:0], d};
    prev <= q[N-1];
  end
  assign rise = q[N-1] & ~prev;
  assign fall = ~q[N-1] & prev;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 secondary; optional o_frame_err via SPI_PERIPHERAL_FRAME_ERR_EN
module spi_peripheral
  import spi_types::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       csb,
  input  logic       mosi,
  output logic       miso,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_underrun,
  output logic [2:0] bit_counter
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
  ,
  output logic       o_frame_err
`endif
);
  localparam logic [2:0] BC_TOP = 3'(SPI_BYTE_BITS - 1);
  spi_peripheral_state_t state;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s, full, load, wr;
  logic [7:0] hold, tx_sh;
  logic [6:0] rx_sh;
  spi_edge_sync #(.N(SYNC_STAGES)) u_sclk (.clk(clk), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.N(SYNC_STAGES)) u_csb (.clk(clk), .d(csb), .rise(csb_rise), .fall(csb_fall));
  // mosi needs only the chain, aligned with the sclk edge detection
  always_ff @(posedge clk) mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign load = !csb_rise && ((state == S_IDLE && csb_fall) || (state == S_RELOAD && sclk_fall));
  assign wr = i_valid && !full;
  assign i_ready = !full;
  assign miso = tx_sh[7] & (state != S_IDLE);
  // One-entry holding register; a load always empties it, dropping a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      hold <= '0;
    end else if (load) full <= 1'b0;
    else if (wr) begin
      full <= 1'b1;
      hold <= i_data;
    end
  end
  // Transaction FSM: byte loads, rx/tx shifting, csb-rise abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rx_sh <= '0;
      tx_sh <= '0;
      bit_counter <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_underrun <= 1'b0;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
      o_frame_err <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_underrun <= load && !full;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
      o_frame_err <= csb_rise && state == S_SHIFT && bit_counter != BC_TOP;
`endif
      if (load) begin
        tx_sh <= full ? hold : '0;
        rx_sh <= '0;
        bit_counter <= BC_TOP;
        state <= S_SHIFT;
      end
      if (csb_rise) state <= S_IDLE;
      else if (state == S_SHIFT && sclk_rise) begin
        rx_sh <= {rx_sh[5:0], mosi_s};
        if (bit_counter == 3'd0) begin
          o_data <= {rx_sh, mosi_s};
          o_valid <= 1'b1;
          state <= S_RELOAD;
        end else bit_counter <= bit_counter - 3'd1;
      end else if (state == S_SHIFT && sclk_fall) tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end
endmodule
